// File: rtl/johnson_pkg.sv
// Shared constants for the Johnson phase monitor: FSM encoding, legal codes, widths.
package johnson_pkg;

  localparam int unsigned CODE_W     = 4;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned NUM_PHASES = 8;
  localparam int unsigned LOCK_W     = 4;
  localparam int unsigned ERR_W      = 8;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKING  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [CODE_W-1:0] CODE_P0 = 4'b0000;
  localparam logic [CODE_W-1:0] CODE_P1 = 4'b0001;
  localparam logic [CODE_W-1:0] CODE_P2 = 4'b0011;
  localparam logic [CODE_W-1:0] CODE_P3 = 4'b0111;
  localparam logic [CODE_W-1:0] CODE_P4 = 4'b1111;
  localparam logic [CODE_W-1:0] CODE_P5 = 4'b1110;
  localparam logic [CODE_W-1:0] CODE_P6 = 4'b1100;
  localparam logic [CODE_W-1:0] CODE_P7 = 4'b1000;

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: phase index and legality of a 4-bit code.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [PHASE_W-1:0] phase_c,
  output logic               valid_c
);

  always_comb begin
    phase_c = '0;
    valid_c = 1'b1;
    case (code)
      CODE_P0: phase_c = 3'd0;
      CODE_P1: phase_c = 3'd1;
      CODE_P2: phase_c = 3'd2;
      CODE_P3: phase_c = 3'd3;
      CODE_P4: phase_c = 3'd4;
      CODE_P5: phase_c = 3'd5;
      CODE_P6: phase_c = 3'd6;
      CODE_P7: phase_c = 3'd7;
      default: valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Monitors a 4-bit Johnson counter: decodes phase, checks transitions,
// tracks lock, and counts errors and full-cycle wraps.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CYCLE_W    = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic [CODE_W-1:0]     johnson_in,
  input  logic                  clear_err,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_onehot,
  output logic                  valid_code,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [ERR_W-1:0]      err_count,
  output logic                  cycle_pulse,
  output logic [CYCLE_W-1:0]    cycle_count
);

  logic [CODE_W-1:0]  prev_code;
  logic               first_q;
  logic [1:0]         state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d, lock_inc_c;

  logic [PHASE_W-1:0] cur_phase_c, prev_phase_c;
  logic               cur_valid_c, prev_valid_c;
  logic               accept_c, hold_c, advance_c, err_c, wrap_c;

  johnson_decode u_dec_cur (
    .code    (johnson_in),
    .phase_c (cur_phase_c),
    .valid_c (cur_valid_c)
  );

  johnson_decode u_dec_prev (
    .code    (prev_code),
    .phase_c (prev_phase_c),
    .valid_c (prev_valid_c)
  );

  // Transition classification; the first sample after reset is only checked for legality.
  always_comb begin
    accept_c  = cur_valid_c && (first_q || prev_valid_c);
    hold_c    = !first_q && accept_c && (cur_phase_c == prev_phase_c);
    advance_c = !first_q && accept_c && (cur_phase_c == PHASE_W'(prev_phase_c + 3'd1));
    err_c     = !accept_c || (!first_q && !hold_c && !advance_c);
    wrap_c    = advance_c && (prev_phase_c == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      state_q    <= ST_UNLOCKED;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // An error drops lock; if the offending code is itself legal, locking restarts from it at once.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    lock_inc_c = LOCK_W'(lock_cnt_q + 4'd1);
    if (err_c) begin
      lock_cnt_d = '0;
      state_d    = cur_valid_c ? ST_LOCKING : ST_UNLOCKED;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d    = ST_LOCKING;
          lock_cnt_d = '0;
        end
        ST_LOCKING: begin
          if (advance_c) begin
            lock_cnt_d = lock_inc_c;
            if (lock_inc_c == LOCK_W'(LOCK_COUNT)) state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          state_d = ST_LOCKED;
        end
        default: begin
          state_d    = ST_UNLOCKED;
          lock_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      prev_code    <= '0;
      first_q      <= 1'b1;
      phase        <= '0;
      phase_onehot <= '0;
      valid_code   <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      cycle_pulse  <= 1'b0;
      err_count    <= '0;
      cycle_count  <= '0;
    end else begin
      prev_code    <= johnson_in;
      first_q      <= 1'b0;
      valid_code   <= accept_c;
      phase_onehot <= accept_c ? (NUM_PHASES'(1) << cur_phase_c) : '0;
      if (accept_c) phase <= cur_phase_c;
      locked       <= (state_d == ST_LOCKED);
      err_pulse    <= err_c;
      cycle_pulse  <= wrap_c;
      if (wrap_c) cycle_count <= CYCLE_W'(cycle_count + CYCLE_W'(1));
      if (clear_err) begin
        err_count <= err_c ? ERR_W'(1) : '0;
      end else if (err_c && (err_count != {ERR_W{1'b1}})) begin
        err_count <= ERR_W'(err_count + 8'd1);
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomised and directed bench for johnson_phase_monitor against a phase-level reference model.
module tb_johnson_phase_monitor;

  localparam int LOCK_COUNT = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] jin;
  logic       clear_err;

  logic [2:0] phase;
  logic [7:0] phase_onehot;
  logic       valid_code, locked, err_pulse, cycle_pulse;
  logic [7:0] err_count;
  logic [7:0] cycle_count;

  logic [2:0] d2_phase;
  logic [7:0] d2_onehot;
  logic       d2_valid, d2_locked, d2_err, d2_cp;
  logic [7:0] d2_err_count;
  logic [1:0] d2_cycle_count;

  johnson_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .CYCLE_W(8)) dut (
    .clk(clk), .sync_reset(rst_n), .johnson_in(jin), .clear_err(clear_err),
    .phase(phase), .phase_onehot(phase_onehot), .valid_code(valid_code),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .cycle_pulse(cycle_pulse), .cycle_count(cycle_count)
  );

  johnson_phase_monitor #(.LOCK_COUNT(LOCK_COUNT), .CYCLE_W(2)) dut2 (
    .clk(clk), .sync_reset(rst_n), .johnson_in(jin), .clear_err(clear_err),
    .phase(d2_phase), .phase_onehot(d2_onehot), .valid_code(d2_valid),
    .locked(d2_locked), .err_pulse(d2_err), .err_count(d2_err_count),
    .cycle_pulse(d2_cp), .cycle_count(d2_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] codes [8];
  initial begin
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
    codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ph(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  // Reference model: phase-level rules, lock = advances since the last error.
  bit         m_started = 0;
  bit         m_first = 1;
  int         m_prev_ph = -1;
  int         m_adv = 0;
  logic [2:0] e_phase = '0;
  logic [7:0] e_oh = '0;
  bit         e_valid = 0, e_locked = 0, e_err = 0, e_cp = 0;
  int         e_ec = 0, e_cc = 0;

  task automatic model_step();
    int p, q;
    bit acc, err, adv;
    m_started = 1;
    if (!rst_n) begin
      e_phase = '0; e_oh = '0; e_valid = 0; e_locked = 0; e_err = 0; e_cp = 0;
      e_ec = 0; e_cc = 0; m_first = 1; m_adv = 0; m_prev_ph = -1;
    end else begin
      p   = ph(jin);
      q   = m_prev_ph;
      acc = (p >= 0) && (m_first || q >= 0);
      adv = acc && !m_first && (p == (q + 1) % 8);
      err = !acc || (!m_first && p != q && p != (q + 1) % 8);
      e_valid = acc;
      e_oh    = acc ? 8'(1 << p) : 8'd0;
      if (acc) e_phase = 3'(p);
      e_err = err;
      if (err) m_adv = 0;
      else if (adv && m_adv < 1000) m_adv++;
      e_locked = (m_adv >= LOCK_COUNT);
      e_cp = adv && (q == 7);
      if (e_cp) e_cc++;
      if (clear_err) e_ec = err ? 1 : 0;
      else if (err && e_ec < 255) e_ec++;
      m_prev_ph = p;
      m_first = 0;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (m_started) begin
      chk("phase", 32'(phase), 32'(e_phase));
      chk("phase_onehot", 32'(phase_onehot), 32'(e_oh));
      chk("valid_code", 32'(valid_code), 32'(e_valid));
      chk("locked", 32'(locked), 32'(e_locked));
      chk("err_pulse", 32'(err_pulse), 32'(e_err));
      chk("err_count", 32'(err_count), 32'(e_ec));
      chk("cycle_pulse", 32'(cycle_pulse), 32'(e_cp));
      chk("cycle_count", 32'(cycle_count), 32'(e_cc % 256));
      chk("cycle_count_w2", 32'(d2_cycle_count), 32'(e_cc % 4));
      chk("locked_w2", 32'(d2_locked), 32'(e_locked));
    end
  end

  int pos = 0;

  task automatic step(input logic r, input logic [3:0] j, input logic c);
    @(negedge clk);
    rst_n = r; jin = j; clear_err = c;
    @(posedge clk);
    #2;
  endtask

  task automatic adv();
    pos++;
    step(1'b1, codes[pos % 8], 1'b0);
  endtask

  initial begin
    int r;
    logic [3:0] j;
    rst_n = 1'b0; jin = 4'h5; clear_err = 1'b0;
    step(1'b0, 4'h5, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_phase", 32'(phase), 0);

    // Free-running sequence: lock on 4th advance, wraps counted.
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, codes[i % 8], 1'b0);
      if (i == 3) chk("lock_before_4th", 32'(locked), 0);
      if (i == 4) chk("lock_at_4th", 32'(locked), 1);
      if (i == 8) begin
        chk("wrap1_pulse", 32'(cycle_pulse), 1);
        chk("wrap1_count", 32'(cycle_count), 1);
      end
      if (i == 9) chk("wrap1_pulse_drop", 32'(cycle_pulse), 0);
      if (i == 16) chk("wrap2_count", 32'(cycle_count), 2);
    end
    pos = 16;

    // Illegal code while locked.
    step(1'b1, 4'b0101, 1'b0);
    chk("illegal_err", 32'(err_pulse), 1);
    chk("illegal_valid", 32'(valid_code), 0);
    chk("illegal_onehot", 32'(phase_onehot), 0);
    chk("illegal_locked", 32'(locked), 0);
    chk("illegal_err_count", 32'(err_count), 1);
    adv();
    chk("legal_after_illegal_err", 32'(err_pulse), 1);
    chk("legal_after_illegal_valid", 32'(valid_code), 0);
    for (int i = 0; i < 7; i++) adv();
    while (pos % 8 != 2) adv();
    chk("relocked", 32'(locked), 1);

    // Skip 0011 -> 1111 while locked.
    step(1'b1, 4'b1111, 1'b0);
    pos = 4;
    chk("skip_err", 32'(err_pulse), 1);
    chk("skip_locked", 32'(locked), 0);
    chk("skip_phase", 32'(phase), 4);
    for (int k = 1; k <= 4; k++) begin
      adv();
      chk("skip_relock", 32'(locked), (k == 4) ? 1 : 0);
    end

    // Hold mid-locking.
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, codes[0], 1'b0);
    pos = 0;
    adv(); adv(); adv();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, codes[3], 1'b0);
      chk("hold_err", 32'(err_pulse), 0);
      chk("hold_locked", 32'(locked), 0);
    end
    adv();
    chk("hold_then_lock", 32'(locked), 1);

    // Error counter saturation and clear.
    for (int i = 0; i < 300; i++) step(1'b1, 4'b0101, 1'b0);
    chk("err_sat", 32'(err_count), 255);
    step(1'b1, 4'b0101, 1'b1);
    chk("clear_with_err", 32'(err_count), 1);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    chk("clear_alone", 32'(err_count), 0);
    pos = 0;

    // Randomised traffic: mostly advances, some holds, jumps, illegal codes, clears, resets.
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      end else if (r < 72) begin
        pos++;
        step(1'b1, codes[pos % 8], ($urandom_range(0, 19) == 0));
      end else if (r < 87) begin
        step(1'b1, codes[pos % 8], ($urandom_range(0, 19) == 0));
      end else begin
        j = 4'($urandom_range(0, 15));
        if (ph(j) >= 0) pos = ph(j);
        step(1'b1, j, ($urandom_range(0, 19) == 0));
      end
    end

    // Narrow cycle counter wraps back to 0 after 4 wraps; reset mid-lock clears everything.
    step(1'b0, 4'h0, 1'b0);
    step(1'b1, codes[0], 1'b0);
    pos = 0;
    for (int i = 0; i < 32; i++) adv();
    chk("w2_four_wraps", 32'(d2_cycle_count), 0);
    chk("w8_four_wraps", 32'(cycle_count), 4);
    chk("locked_before_reset", 32'(locked), 1);
    step(1'b0, 4'b0011, 1'b1);
    chk("rst_mid_phase", 32'(phase), 0);
    chk("rst_mid_onehot", 32'(phase_onehot), 0);
    chk("rst_mid_valid", 32'(valid_code), 0);
    chk("rst_mid_locked", 32'(locked), 0);
    chk("rst_mid_err", 32'(err_pulse), 0);
    chk("rst_mid_cp", 32'(cycle_pulse), 0);
    chk("rst_mid_cc", 32'(cycle_count), 0);
    chk("rst_mid_ec", 32'(err_count), 0);
    step(1'b1, 4'b0011, 1'b0);
    chk("first_after_rst_err", 32'(err_pulse), 0);
    chk("first_after_rst_phase", 32'(phase), 2);
    step(1'b1, 4'b0101, 1'b0);
    chk("illegal_after_rst_ec", 32'(err_count), 1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
